dbbif_copy_master: RTL
======================

DBBIF_COPY_MASTER -- requirements
Module: dbbif_copy_master

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 32, address width; DATA_WIDTH, default 64, data width (32/64/128/256/512); RD_ID, default 8'h01, arid; WR_ID, default 8'h02, awid.
REQ-002 SHALL have ports (name  direction  width  meaning):
  clk  in  1  clock, rising edge
  rst_n  in  1  reset, asynchronous, active-low
  cmd_valid  in  1  copy request valid
  cmd_ready  out  1  engine idle, request accepted on valid&ready
  cmd_src_addr  in  ADDR_WIDTH  source byte address
  cmd_dst_addr  in  ADDR_WIDTH  destination byte address
  cmd_beats  in  8  beat count minus 1 (0..255 = 1..256 beats)
  busy  out  1  transfer in progress
  done  out  1  one-cycle pulse, transfer complete
  err  out  1  sticky id-mismatch flag, cleared on cmd accept
  nvdla_core2dbb_aw_awvalid/awready/awlen/awaddr/awid  out/in/out/out/out  1/1/4/ADDR_WIDTH/8  write address
  nvdla_core2dbb_w_wvalid/wready/wdata/wlast/wstrb  out/in/out/out/out  1/1/DATA_WIDTH/1/DATA_WIDTH/8  write data
  nvdla_core2dbb_b_bvalid/bready/bid  in/out/in  1/1/8  write response
  nvdla_core2dbb_ar_arvalid/arready/arlen/araddr/arid  out/in/out/out/out  1/1/4/ADDR_WIDTH/8  read address
  nvdla_core2dbb_r_rvalid/rready/rlast/rdata/rid  in/out/in/DATA_WIDTH/8  read data

Function
REQ-003 SHALL copy (cmd_beats+1) DATA_WIDTH-bit beats from src to dst; low log2(DATA_WIDTH/8) address bits forced to zero at accept.
REQ-004 SHALL split the transfer into bursts of L = min(remaining, 16, beats to next 4096-byte boundary of src, same for dst); arlen = awlen = L-1.
REQ-005 SHALL run FSM IDLE -> RD_ADDR -> RD_DATA -> WR_ADDR -> WR_DATA -> WR_RESP -> (remaining>0 ? RD_ADDR : IDLE); one burst outstanding at a time.
REQ-006 IDLE: cmd_ready=1; on cmd accept latch addresses/count, clear err, go RD_ADDR; arvalid asserted the next cycle.
REQ-007 RD_ADDR: arvalid=1 with stable araddr/arlen/arid until arready sampled high; then RD_DATA.
REQ-008 RD_DATA: rready=1; each rvalid beat stored into 16-entry buffer at beat index; rlast (or L-th beat) -> WR_ADDR; rid != RD_ID sets err.
REQ-009 WR_ADDR: awvalid=1, stable fields until awready; then WR_DATA.
REQ-010 WR_DATA: wvalid=1, wdata=buffer[index], wstrb all ones, wlast on beat L; index advances only on wvalid&wready; after wlast handshake -> WR_RESP.
REQ-011 WR_RESP: bready=1 held; on bvalid advance src/dst by L*DATA_WIDTH/8, remaining -= L; bid != WR_ID sets err.
REQ-012 done SHALL pulse for exactly one cycle the cycle after the final bvalid; busy = (state != IDLE).
REQ-013 valid outputs SHALL be registered and SHALL NOT drop before handshake; cmd_valid while busy is ignored (cmd_ready=0).
REQ-014 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH; remaining counter 9 bits.

Reset
REQ-015 On rst_n low, immediately: state IDLE, all valid/ready outputs 0 except cmd_ready=1, busy/done/err 0, addr/len/id/data outputs 0, counters 0.
REQ-016 Reset mid-burst SHALL abandon the transfer without done; buffer contents need not be cleared.

Structure
REQ-017 Shared package dbbif_pkg SHALL hold the FSM state enum, BURST_MAX=16, BOUNDARY_BYTES=4096.
REQ-018 Burst-length calculation SHALL be sub-module dbbif_burst_calc (combinational, inputs src, dst, remaining; output L).

Verification (bench: dbbif_dram_model, MEM_SIZE 8192, DATA_WIDTH 64)
REQ-019 src 0x000, dst 0x100, beats 0 -> one AR arlen 0, one AW awlen 0, wlast on first beat, mem[0x100..0x107]=mem[0x000..0x007], done pulse once.
REQ-020 src 0x000, dst 0x400, beats 15 -> single burst arlen/awlen 15, 128 bytes copied, err 0.
REQ-021 src 0x000, dst 0x800, beats 39 -> bursts L=16,16,8 at dst 0x800, 0x880, 0x900.
REQ-022 src 0xFF0, dst 0x1800, beats 3 -> bursts L=2 (araddr 0xFF0) then L=2 (araddr 0x1000).
REQ-023 random arready/awready/wready stalls and delayed bready-observed bvalid over beats 255 -> byte-exact copy, stable fields while stalled.
REQ-024 rst_n low during WR_DATA -> next cycle all valids 0, cmd_ready 1, no done; new command completes correctly.

Source files
------------

// File: rtl/dbbif_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dbbif_pkg
//  Description : Shared types and constants for the DBBIF copy master:
//                FSM state encoding, burst ceiling and address boundary.
//  Revision    : 1.0  initial release
// ============================================================================
package dbbif_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_ADDR = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_WR_RESP = 3'd5
    } dbbif_state_e;

    // Longest burst the AXI-style 4-bit len field can describe.
    localparam int BURST_MAX      = 16;
    // No burst may cross this address boundary on either side of the copy.
    localparam int BOUNDARY_BYTES = 4096;

endpackage
`default_nettype wire

// File: rtl/dbbif_burst_calc.sv
`default_nettype none
// ============================================================================
//  Module      : dbbif_burst_calc
//  Description : Combinational burst length: the smallest of the beats still
//                to copy, BURST_MAX, and the beats left before the next
//                BOUNDARY_BYTES boundary of the source and of the destination.
//  Revision    : 1.0  initial release
// ============================================================================
module dbbif_burst_calc
    import dbbif_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic [ADDR_WIDTH-1:0] src_i,
    input  logic [ADDR_WIDTH-1:0] dst_i,
    input  logic [8:0]            remaining_i,
    output logic [4:0]            len_o
);

    localparam int                    BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] BND        = ADDR_WIDTH'(BOUNDARY_BYTES);

    logic [ADDR_WIDTH-1:0] src_room;
    logic [ADDR_WIDTH-1:0] dst_room;

    // Addresses are beat aligned, so the room is always at least one beat.
    assign src_room = (BND - (src_i & (BND - 1'b1))) >> BYTE_SHIFT;
    assign dst_room = (BND - (dst_i & (BND - 1'b1))) >> BYTE_SHIFT;

    // Running minimum, starting from the burst ceiling.
    always_comb begin
        len_o = 5'(BURST_MAX);
        if (ADDR_WIDTH'(remaining_i) < ADDR_WIDTH'(len_o)) len_o = remaining_i[4:0];
        if (src_room < ADDR_WIDTH'(len_o))                 len_o = src_room[4:0];
        if (dst_room < ADDR_WIDTH'(len_o))                 len_o = dst_room[4:0];
    end

endmodule
`default_nettype wire

// File: rtl/dbbif_copy_master.sv
`default_nettype none
// ============================================================================
//  Module      : dbbif_copy_master
//  Description : Memory-to-memory copy engine on the NVDLA DBB (AXI-like)
//                port. Reads one burst into a 16-entry buffer, writes it back
//                out, waits for the response, and repeats until done. One
//                burst is in flight at a time.
//  Revision    : 1.0  initial release
// ============================================================================
module dbbif_copy_master
    import dbbif_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 64,
    parameter logic [7:0] RD_ID      = 8'h01,
    parameter logic [7:0] WR_ID      = 8'h02
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_src_addr,
    input  logic [ADDR_WIDTH-1:0]   cmd_dst_addr,
    input  logic [7:0]              cmd_beats,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    nvdla_core2dbb_aw_awvalid,
    input  logic                    nvdla_core2dbb_aw_awready,
    output logic [3:0]              nvdla_core2dbb_aw_awlen,
    output logic [ADDR_WIDTH-1:0]   nvdla_core2dbb_aw_awaddr,
    output logic [7:0]              nvdla_core2dbb_aw_awid,
    output logic                    nvdla_core2dbb_w_wvalid,
    input  logic                    nvdla_core2dbb_w_wready,
    output logic [DATA_WIDTH-1:0]   nvdla_core2dbb_w_wdata,
    output logic                    nvdla_core2dbb_w_wlast,
    output logic [DATA_WIDTH/8-1:0] nvdla_core2dbb_w_wstrb,
    input  logic                    nvdla_core2dbb_b_bvalid,
    output logic                    nvdla_core2dbb_b_bready,
    input  logic [7:0]              nvdla_core2dbb_b_bid,
    output logic                    nvdla_core2dbb_ar_arvalid,
    input  logic                    nvdla_core2dbb_ar_arready,
    output logic [3:0]              nvdla_core2dbb_ar_arlen,
    output logic [ADDR_WIDTH-1:0]   nvdla_core2dbb_ar_araddr,
    output logic [7:0]              nvdla_core2dbb_ar_arid,
    input  logic                    nvdla_core2dbb_r_rvalid,
    output logic                    nvdla_core2dbb_r_rready,
    input  logic                    nvdla_core2dbb_r_rlast,
    input  logic [DATA_WIDTH-1:0]   nvdla_core2dbb_r_rdata,
    input  logic [7:0]              nvdla_core2dbb_r_rid
);

    localparam int                    STRB_W     = DATA_WIDTH / 8;
    localparam int                    BYTE_SHIFT = $clog2(STRB_W);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_W - 1);

    dbbif_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [8:0]            rem_q, rem_d;
    logic [3:0]            lenm1_q, lenm1_d;
    logic [3:0]            ridx_q, ridx_d;
    logic [3:0]            widx_q, widx_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;
    logic                  cmd_ready_q, busy_q;
    logic                  arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic [7:0]            arid_q, awid_q;
    logic [DATA_WIDTH-1:0] buf_q [BURST_MAX];
    logic                  buf_we;
    logic [4:0]            burst_len;
    logic [4:0]            cur_len;
    logic [ADDR_WIDTH-1:0] step;

    // Length is sized from the values the engine is about to hold, so it is
    // ready to latch on the same edge that enters RD_ADDR.
    dbbif_burst_calc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_burst_calc (
        .src_i       (src_d),
        .dst_i       (dst_d),
        .remaining_i (rem_d),
        .len_o       (burst_len)
    );

    assign cur_len = {1'b0, lenm1_q} + 5'd1;
    assign step    = ADDR_WIDTH'(cur_len) << BYTE_SHIFT;

    // Next-state and datapath updates for the copy sequence.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        lenm1_d = lenm1_q;
        ridx_d  = ridx_q;
        widx_d  = widx_q;
        err_d   = err_q;
        done_d  = 1'b0;
        buf_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    src_d   = cmd_src_addr & ALIGN_MASK;
                    dst_d   = cmd_dst_addr & ALIGN_MASK;
                    rem_d   = {1'b0, cmd_beats} + 9'd1;
                    err_d   = 1'b0;
                    state_d = ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: begin
                if (arvalid_q && nvdla_core2dbb_ar_arready) begin
                    ridx_d  = 4'd0;
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (rready_q && nvdla_core2dbb_r_rvalid) begin
                    buf_we = 1'b1;
                    ridx_d = ridx_q + 4'd1;
                    if (nvdla_core2dbb_r_rid != RD_ID) err_d = 1'b1;
                    if (nvdla_core2dbb_r_rlast || (ridx_q == lenm1_q)) state_d = ST_WR_ADDR;
                end
            end
            ST_WR_ADDR: begin
                if (awvalid_q && nvdla_core2dbb_aw_awready) begin
                    widx_d  = 4'd0;
                    state_d = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (wvalid_q && nvdla_core2dbb_w_wready) begin
                    if (widx_q == lenm1_q) state_d = ST_WR_RESP;
                    else                   widx_d  = widx_q + 4'd1;
                end
            end
            ST_WR_RESP: begin
                if (bready_q && nvdla_core2dbb_b_bvalid) begin
                    if (nvdla_core2dbb_b_bid != WR_ID) err_d = 1'b1;
                    src_d = src_q + step;
                    dst_d = dst_q + step;
                    rem_d = rem_q - 9'(cur_len);
                    if (rem_q == 9'(cur_len)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RD_ADDR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if ((state_d == ST_RD_ADDR) && (state_q != ST_RD_ADDR)) lenm1_d = 4'(burst_len - 5'd1);
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            rem_q       <= '0;
            lenm1_q     <= '0;
            ridx_q      <= '0;
            widx_q      <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arid_q      <= '0;
            awid_q      <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            rem_q       <= rem_d;
            lenm1_q     <= lenm1_d;
            ridx_q      <= ridx_d;
            widx_q      <= widx_d;
            err_q       <= err_d;
            done_q      <= done_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            busy_q      <= (state_d != ST_IDLE);
            arvalid_q   <= (state_d == ST_RD_ADDR);
            rready_q    <= (state_d == ST_RD_DATA);
            awvalid_q   <= (state_d == ST_WR_ADDR);
            wvalid_q    <= (state_d == ST_WR_DATA);
            bready_q    <= (state_d == ST_WR_RESP);
            arid_q      <= RD_ID;
            awid_q      <= WR_ID;
        end
    end

    // Burst buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (buf_we) buf_q[ridx_q] <= nvdla_core2dbb_r_rdata;
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    assign nvdla_core2dbb_ar_arvalid = arvalid_q;
    assign nvdla_core2dbb_ar_araddr  = src_q;
    assign nvdla_core2dbb_ar_arlen   = lenm1_q;
    assign nvdla_core2dbb_ar_arid    = arid_q;
    assign nvdla_core2dbb_r_rready   = rready_q;

    assign nvdla_core2dbb_aw_awvalid = awvalid_q;
    assign nvdla_core2dbb_aw_awaddr  = dst_q;
    assign nvdla_core2dbb_aw_awlen   = lenm1_q;
    assign nvdla_core2dbb_aw_awid    = awid_q;

    assign nvdla_core2dbb_w_wvalid   = wvalid_q;
    assign nvdla_core2dbb_w_wdata    = wvalid_q ? buf_q[widx_q] : '0;
    assign nvdla_core2dbb_w_wlast    = wvalid_q && (widx_q == lenm1_q);
    assign nvdla_core2dbb_w_wstrb    = {STRB_W{wvalid_q}};
    assign nvdla_core2dbb_b_bready   = bready_q;

endmodule
`default_nettype wire
